muldiv_unit: RTL and testbench

//   Iterative RV32M multiply/divide execute unit. It consumes the decoded M-extension op (funct3)
//   and two register operands from the EX stage, and computes the result over XLEN cycles.
//   It is the sequential counterpart of the single-cycle ALU path: EX stalls while busy_o is high.
//   It then retires the result with a one-cycle done_o pulse.

---
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit.sv | 157 +++++++++++++++
 tb/tb_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the EX stage (master) and the iterative multiply/divide unit (slave).
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, funct3_i, rs1_i, rs2_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, rs1_i, rs2_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one product/quotient bit per cycle on operand magnitudes,
// sign fix-up and divide special cases applied on the final edge; fixed XLEN+1 cycle latency.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] p_q, p_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic              accept, last;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] p_step, prod_fix;
  logic [XLEN-1:0]   quo, rem, final_res;

  assign accept = (state_q == IDLE) && bus.start_i && !bus.flush_i;
  assign last   = (state_q == CALC) && (cnt_q == CW'(XLEN - 1));

  // Operand decode: signedness per funct3, then magnitudes fed to the unsigned datapath.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.funct3_i)
      3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                 a_signed = 1'b1;
      default:                ;
    endcase
    a_neg = a_signed & bus.rs1_i[XLEN-1];
    b_neg = b_signed & bus.rs2_i[XLEN-1];
    mag_a = a_neg ? -bus.rs1_i : bus.rs1_i;
    mag_b = b_neg ? -bus.rs2_i : bus.rs2_i;
  end

  // One iteration. p_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : '0);
    div_shift = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) p_step = {div_diff[XLEN-1:0],  p_q[XLEN-2:0], 1'b1};
      else                 p_step = {div_shift[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
    end else begin
      p_step = {mul_sum, p_q[XLEN-1:1]};
    end

    prod_fix = neg_q ? -p_step : p_step;
    quo      = p_step[XLEN-1:0];
    rem      = p_step[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = div0_q ? '1 : (ovf_q ? rs1_q : (neg_q ? -quo : quo));
      default:                final_res = div0_q ? rs1_q : (ovf_q ? '0 : (neg_q ? -rem : rem));
    endcase
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    rs1_d    = rs1_q;
    b_d      = b_q;
    p_d      = p_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (accept) begin
      op_d   = bus.funct3_i;
      neg_d  = (bus.funct3_i == 3'b110) ? a_neg : (a_neg ^ b_neg);
      div0_d = bus.funct3_i[2] && (bus.rs2_i == '0);
      ovf_d  = (bus.funct3_i == 3'b100 || bus.funct3_i == 3'b110) &&
               (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_i == '1);
      rs1_d  = bus.rs1_i;
      b_d    = bus.funct3_i[2] ? mag_b : mag_a;
      p_d    = {{XLEN{1'b0}}, (bus.funct3_i[2] ? mag_a : mag_b)};
      cnt_d  = '0;
    end else if (bus.flush_i) begin
      cnt_d = '0;
    end else if (state_q == CALC) begin
      p_d   = p_step;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        result_d = final_res;
        done_d   = 1'b1;
        cnt_d    = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start_i) state_d = CALC;
        CALC:    if (last)        state_d = DONE;
        DONE:                     state_d = IDLE;
        default:                  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy_o   = (state_q != IDLE);
    bus.done_o   = done_q;
    bus.result_o = result_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rs1_q    <= '0;
      b_q      <= '0;
      p_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      rs1_q    <= rs1_d;
      b_q      <= b_d;
      p_q      <= p_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table-driven vectors through a result scoreboard,
// plus hand-written hold/flush/reset sequences.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;

  always @(negedge clk_i) if (bus.done_o) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model in plain wide arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    logic [63:0]     p;
    logic [31:0]     r;
    int              ia = a;
    int              ib = b;
    case (f3)
      3'b000: begin p = ua * ub;           r = p[31:0];  end
      3'b001: begin p = sa * sb;           r = p[63:32]; end
      3'b010: begin p = sa * longint'(ub); r = p[63:32]; end
      3'b011: begin p = ua * ub;           r = p[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
        else r = ia / ib;
      end
      3'b101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
        else r = ia % ib;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic add(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Presents a request for one edge; leaves start_i high when hold is set.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit hold, input bit push);
    bus.start_i  = 1'b1;
    bus.funct3_i = f3;
    bus.rs1_i    = a;
    bus.rs2_i    = b;
    if (push) exp_q.push_back(exp);
    tick();
    if (!hold) bus.start_i = 1'b0;
    bus.rs1_i    = $urandom;
    bus.rs2_i    = $urandom;
    bus.funct3_i = 3'($urandom);
  endtask

  // Called in the cycle after acceptance (T+1); returns in the done cycle (expected T+33).
  task automatic wait_done(input string nm, input bit scramble);
    int          lat = 1;
    logic [31:0] exp;
    check({nm, "_busy"}, 32'(bus.busy_o), 32'd1);
    while (!bus.done_o && lat < 40) begin
      if (scramble) begin
        bus.rs1_i    = $urandom;
        bus.rs2_i    = $urandom;
        bus.funct3_i = 3'($urandom);
      end
      tick();
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'd33);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    check({nm, "_result"}, bus.result_o, exp);
    check({nm, "_busy_in_done"}, 32'(bus.busy_o), 32'd1);
  endtask

  initial begin
    int          d0;
    string       nm;
    logic [31:0] ra, rb;
    logic [2:0]  rf;

    rst_i        = 1'b1;
    bus.start_i  = 1'b0;
    bus.flush_i  = 1'b0;
    bus.funct3_i = 3'b000;
    bus.rs1_i    = '0;
    bus.rs2_i    = '0;
    tick();
    tick();
    check("reset_busy",   32'(bus.busy_o), 32'd0);
    check("reset_done",   32'(bus.done_o), 32'd0);
    check("reset_result", bus.result_o,    32'd0);
    rst_i = 1'b0;
    tick();

    add(3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB);
    add(3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE);
    add(3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD);
    add(3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF);
    add(3'b101, 32'd100,        32'd7,        32'd14);
    add(3'b111, 32'd100,        32'd7,        32'd2);
    add(3'b100, 32'd5,          32'd0,        32'hFFFFFFFF);
    add(3'b111, 32'd5,          32'd0,        32'd5);
    add(3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000);
    add(3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0);
    add(3'b001, 32'h80000000,   32'h80000000, 32'h40000000);
    add(3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF);
    add(3'b001, 32'hFFFFFFFE,   32'd3,        32'hFFFFFFFF);
    add(3'b110, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9);
    add(3'b110, 32'd7,          32'hFFFFFFFE, 32'd1);
    add(3'b100, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD);
    add(3'b101, 32'd0,          32'd0,        32'hFFFFFFFF);
    for (int i = 0; i < 10; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 2 == 1) rb = -rb;
      add(rf, ra, rb, model(rf, ra, rb));
    end

    foreach (vecs[i]) begin
      nm = $sformatf("vec%0d_f%0d", i, vecs[i].f3);
      start_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 1'b1);
      wait_done(nm, 1'b0);
      tick();
      check({nm, "_idle_busy"}, 32'(bus.busy_o), 32'd0);
      check({nm, "_idle_done"}, 32'(bus.done_o), 32'd0);
    end

    // start_i held high and operands scrambled throughout the operation.
    d0 = done_cnt;
    start_op(3'b101, 32'd100, 32'd7, 32'd14, 1'b1, 1'b1);
    wait_done("hold", 1'b1);
    bus.funct3_i = 3'b000;
    bus.rs1_i    = 32'd3;
    bus.rs2_i    = 32'd5;
    exp_q.push_back(32'd15);
    tick();
    check("hold_done_cycle_ignored", 32'(bus.busy_o), 32'd0);
    check("hold_single_pulse", 32'(done_cnt - d0), 32'd1);
    tick();
    bus.start_i = 1'b0;
    wait_done("hold_next", 1'b0);
    tick();

    // Flush mid-operation at T+10.
    d0 = done_cnt;
    start_op(3'b000, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0);
    repeat (9) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("flush_busy",   32'(bus.busy_o), 32'd0);
    check("flush_done",   32'(bus.done_o), 32'd0);
    check("flush_result", bus.result_o,    32'd15);
    repeat (40) tick();
    check("flush_no_done", 32'(done_cnt - d0), 32'd0);
    check("flush_result_held", bus.result_o, 32'd15);

    // Flush together with start in IDLE: request dropped.
    bus.flush_i = 1'b1;
    bus.start_i = 1'b1;
    bus.funct3_i = 3'b000;
    bus.rs1_i = 32'd2;
    bus.rs2_i = 32'd2;
    tick();
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    check("flush_start_busy", 32'(bus.busy_o), 32'd0);
    tick();
    check("flush_start_busy2", 32'(bus.busy_o), 32'd0);

    // Flush during the DONE cycle: done already visible, result kept.
    start_op(3'b000, 32'd4, 32'd4, 32'd16, 1'b0, 1'b1);
    wait_done("flush_in_done", 1'b0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("flush_in_done_busy",   32'(bus.busy_o), 32'd0);
    check("flush_in_done_result", bus.result_o,    32'd16);

    // Reset at T+20 mid-DIV, then a fresh MULHSU.
    start_op(3'b100, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0);
    repeat (19) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_busy",   32'(bus.busy_o), 32'd0);
    check("midrst_done",   32'(bus.done_o), 32'd0);
    check("midrst_result", bus.result_o,    32'd0);
    start_op(3'b010, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 1'b1);
    wait_done("midrst_mulhsu", 1'b0);
    tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
